// File: rtl/regfile_load_sequencer_if.sv
// regfile_load_sequencer_if: word-stream, sweep-control and register-file port bundle
interface regfile_load_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_sel;
   logic [7:0] in_data;
   logic       go;
   logic       bank;
   logic       abort;
   logic [2:0] WriteRegA;
   logic [3:0] WriteDataA;
   logic       WriteEnA;
   logic [3:0] WriteRegB;
   logic [7:0] WriteDataB;
   logic       WriteEnB;
   logic [2:0] ReadRegA1;
   logic [2:0] ReadRegA2;
   logic [3:0] ReadRegB;
   logic       start;
   logic       busy;
   logic       done;
   logic       a_loaded;
   logic       b_loaded;
   modport master (
      output in_valid, in_sel, in_data, go, bank, abort,
      input  in_ready, WriteRegA, WriteDataA, WriteEnA, WriteRegB, WriteDataB, WriteEnB,
      input  ReadRegA1, ReadRegA2, ReadRegB, start, busy, done, a_loaded, b_loaded
   );
   modport slave (
      input  in_valid, in_sel, in_data, go, bank, abort,
      output in_ready, WriteRegA, WriteDataA, WriteEnA, WriteRegB, WriteDataB, WriteEnB,
      output ReadRegA1, ReadRegA2, ReadRegB, start, busy, done, a_loaded, b_loaded
   );
endinterface

// File: rtl/regfile_load_sequencer.sv
// regfile_load_sequencer: loads words into register files A/B and runs read sweeps for the datapath
module regfile_load_sequencer #(
   parameter int SWEEP_LEN = 8
) (
   input logic clk,
   input logic rst,
   regfile_load_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PREP, SWEEP, DONE} state_t;
   state_t     state, stateNext;
   logic [2:0] ptrA, k, kNext;
   logic [3:0] ptrB;
   logic       bankL, accept, wrA, wrB;
   assign bus.in_ready = (state == IDLE) & ~rst;
   assign accept = bus.in_valid & bus.in_ready;
   assign wrA = accept & ~bus.in_sel;
   assign wrB = accept & bus.in_sel;
   // Next state and the sweep index shown in the next cycle (0 whenever not sweeping)
   always_comb begin
      stateNext = state;
      kNext = '0;
      case (state)
         IDLE:  stateNext = bus.go ? PREP : IDLE;
         PREP:  stateNext = SWEEP;
         SWEEP: begin
            if (bus.abort) stateNext = IDLE;
            else if (k == 3'(SWEEP_LEN - 1)) stateNext = DONE;
            else kNext = k + 3'd1;
         end
         DONE:  stateNext = IDLE;
      endcase
   end
   // State register and sweep index
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k <= '0;
      end else begin
         state <= stateNext;
         k <= kNext;
      end
   end
   // Write side: one-cycle write strobes, auto-incrementing pointers, sticky loaded flags
   always_ff @(posedge clk) begin
      if (rst) begin
         ptrA <= '0;
         ptrB <= '0;
         bus.WriteRegA <= '0;
         bus.WriteDataA <= '0;
         bus.WriteEnA <= 1'b0;
         bus.WriteRegB <= '0;
         bus.WriteDataB <= '0;
         bus.WriteEnB <= 1'b0;
         bus.a_loaded <= 1'b0;
         bus.b_loaded <= 1'b0;
      end else begin
         bus.WriteEnA <= wrA;
         bus.WriteEnB <= wrB;
         if (wrA) begin
            bus.WriteRegA <= ptrA;
            bus.WriteDataA <= bus.in_data[3:0];
            ptrA <= ptrA + 3'd1;
            bus.a_loaded <= bus.a_loaded | (ptrA == 3'd7);
         end
         if (wrB) begin
            bus.WriteRegB <= ptrB;
            bus.WriteDataB <= bus.in_data;
            ptrB <= ptrB + 4'd1;
            bus.b_loaded <= bus.b_loaded | (ptrB == 4'd15);
         end
      end
   end
   // Read side: outputs reflect the state being entered so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         bankL <= 1'b0;
         bus.start <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.ReadRegA1 <= '0;
         bus.ReadRegA2 <= '0;
         bus.ReadRegB <= '0;
      end else begin
         if (state == IDLE && bus.go) bankL <= bus.bank;
         bus.start <= stateNext == SWEEP;
         bus.busy <= stateNext != IDLE;
         bus.done <= stateNext == DONE;
         bus.ReadRegA1 <= stateNext == SWEEP ? kNext : 3'd0;
         bus.ReadRegA2 <= stateNext == SWEEP ? 3'd7 - kNext : 3'd0;
         bus.ReadRegB <= stateNext == SWEEP ? {(state == IDLE) ? bus.bank : bankL, kNext} : 4'd0;
      end
   end
endmodule

// File: tb/tb_regfile_load_sequencer.sv
// tb_regfile_load_sequencer: directed plus random stimulus against a cycle-count reference model
module tb_regfile_load_sequencer;
   localparam int SWEEP_LEN = 8;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   phase = 0;
   int   cntA = 0;
   int   cntB = 0;
   logic [2:0] mRegA = '0;
   logic [3:0] mDataA = '0;
   logic [3:0] mRegB = '0;
   logic [7:0] mDataB = '0;
   logic       mWeA = 1'b0;
   logic       mWeB = 1'b0;
   logic       mBank = 1'b0;
   regfile_load_sequencer_if bus ();
   regfile_load_sequencer #(.SWEEP_LEN(SWEEP_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic cycle(input logic r, input logic v, input logic s, input logic [7:0] d,
                        input logic g, input logic b, input logic ab);
      int idx;
      logic sw, acc;
      rst = r;
      bus.in_valid = v;
      bus.in_sel = s;
      bus.in_data = d;
      bus.go = g;
      bus.bank = b;
      bus.abort = ab;
      #1;
      chk("in_ready", 8'(bus.in_ready), 8'(!r && phase == 0));
      if (r) begin
         phase = 0; cntA = 0; cntB = 0; mBank = 1'b0;
         mRegA = '0; mDataA = '0; mRegB = '0; mDataB = '0; mWeA = 1'b0; mWeB = 1'b0;
      end else begin
         acc = v && phase == 0;
         mWeA = acc && !s;
         mWeB = acc && s;
         if (mWeA) begin mRegA = 3'(cntA % 8); mDataA = d[3:0]; cntA++; end
         if (mWeB) begin mRegB = 4'(cntB % 16); mDataB = d; cntB++; end
         if (phase == 0) begin
            if (g) begin phase = 1; mBank = b; end
         end else if (phase == 1) phase = 2;
         else if (phase <= SWEEP_LEN + 1) phase = ab ? 0 : phase + 1;
         else phase = 0;
      end
      sw = phase >= 2 && phase <= SWEEP_LEN + 1;
      idx = sw ? phase - 2 : 0;
      @(posedge clk);
      #1;
      chk("WriteEnA", 8'(bus.WriteEnA), 8'(mWeA));
      chk("WriteRegA", 8'(bus.WriteRegA), 8'(mRegA));
      chk("WriteDataA", 8'(bus.WriteDataA), 8'(mDataA));
      chk("WriteEnB", 8'(bus.WriteEnB), 8'(mWeB));
      chk("WriteRegB", 8'(bus.WriteRegB), 8'(mRegB));
      chk("WriteDataB", bus.WriteDataB, mDataB);
      chk("a_loaded", 8'(bus.a_loaded), 8'(cntA >= 8));
      chk("b_loaded", 8'(bus.b_loaded), 8'(cntB >= 16));
      chk("start", 8'(bus.start), 8'(sw));
      chk("busy", 8'(bus.busy), 8'(phase != 0));
      chk("done", 8'(bus.done), 8'(phase == SWEEP_LEN + 2));
      chk("ReadRegA1", 8'(bus.ReadRegA1), 8'(sw ? idx : 0));
      chk("ReadRegA2", 8'(bus.ReadRegA2), 8'(sw ? 7 - idx : 0));
      chk("ReadRegB", 8'(bus.ReadRegB), 8'(sw ? (mBank ? 8 : 0) + idx : 0));
   endtask
   initial begin
      cycle(1, 0, 0, 8'h00, 0, 0, 0);
      cycle(1, 1, 0, 8'h00, 1, 0, 0);
      cycle(0, 0, 0, 8'h00, 0, 0, 0);
      for (int i = 1; i <= 9; i++) cycle(0, 1, 0, 8'(i), 0, 0, 0);
      for (int i = 0, n = 0; n < 16; i++) begin
         if (i % 3 == 2) cycle(0, 0, 1, 8'hEE, 0, 0, 0);
         else begin cycle(0, 1, 1, 8'(8'h10 + n), 0, 0, 0); n++; end
      end
      cycle(0, 0, 0, 8'h00, 1, 1, 0);
      for (int i = 0; i < SWEEP_LEN + 2; i++) cycle(0, 1, 0, 8'hA5, i % 2 == 0, 0, 0);
      cycle(0, 0, 0, 8'h00, 0, 0, 0);
      cycle(0, 1, 0, 8'h02, 0, 0, 0);
      cycle(0, 1, 0, 8'h05, 1, 0, 0);
      for (int i = 0; i < 16 && phase != 5; i++) cycle(0, 0, 0, 8'h00, 0, 0, 0);
      cycle(0, 0, 0, 8'h00, 0, 0, 1);
      cycle(0, 0, 0, 8'h00, 0, 0, 0);
      cycle(0, 0, 0, 8'h00, 1, 1, 0);
      for (int i = 0; i < 16 && phase != 5; i++) cycle(0, 0, 0, 8'h00, 0, 0, 0);
      cycle(1, 0, 0, 8'h00, 0, 0, 0);
      cycle(0, 1, 1, 8'h77, 0, 0, 0);
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 149) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
               $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 19) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
